// File: rtl/nibble_serial_adder16_if.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder16_if
// Handshake/data bundle between an operand producer, the nibble-serial adder
// and a result consumer.
//   in_valid/in_ready   : operand handshake (producer -> adder)
//   a, b, cin           : operands and carry-in
//   out_valid/out_ready : result handshake (adder -> consumer)
//   sum, cout           : registered result and top carry-out
// Optional (macro SERIAL_ADD_SUB_EN):
//   sub                 : 1 = compute a-b instead of a+b+cin
//   ovf                 : signed overflow of the full-width operation
// Modports: slave = the adder, master = the producer/consumer side.
// -----------------------------------------------------------------------------
interface nibble_serial_adder16_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADD_SUB_EN
   logic             sub;
   logic             ovf;
`endif

   modport slave (
      input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADD_SUB_EN
      input  sub,
      output ovf,
`endif
      output in_ready, out_valid, sum, cout
   );

   modport master (
      output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADD_SUB_EN
      output sub,
      input  ovf,
`endif
      input  in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/nibble_serial_adder16.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder16
// WIDTH-bit adder that reuses one 4-bit carry-lookahead stage over WIDTH/4
// cycles, least significant nibble first. The stage carry-out is registered
// and becomes the carry-in of the next nibble.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : nibble_serial_adder16_if.slave (operand and result handshakes)
//   busy   : high while an operation is in RUN or DONE
// Optional feature macro: SERIAL_ADD_SUB_EN (adds bus.sub / bus.ovf,
// subtract = invert B nibbles and force carry-in of nibble 0 to 1).
// WIDTH must be a multiple of 4 and at least 8; the interface instance must
// use the same WIDTH.
// -----------------------------------------------------------------------------
module nibble_serial_adder16 #(
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   nibble_serial_adder16_if.slave bus,
   output logic                   busy
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   state_t           state_next;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic [IDXW-1:0]  idx_reg;
   logic             carry_reg;
   logic             cout_reg;
`ifdef SERIAL_ADD_SUB_EN
   logic             sub_reg;
   logic             ovf_reg;
`endif

   logic             accept;
   logic             last_nib;

   // Single 4-bit CLA stage
   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       nib_g;
   logic [3:0]       nib_p;
   logic [4:0]       nib_c;
   logic [3:0]       nib_sum;
   logic [3:0]       b_inv;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.in_valid) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_nib) begin
               state_next = DONE;
            end
         end
         DONE: begin
            // Handoff goes back through IDLE, so no operand is taken this edge.
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign last_nib      = (state_reg == RUN) && (idx_reg == LAST_IDX);
   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.out_valid = (state_reg == DONE);
   assign busy          = (state_reg != IDLE);
   assign bus.sum       = sum_reg;
   assign bus.cout      = cout_reg;

   // ---------------------------------------------------- CLA stage inputs
   always_comb begin
      nib_a = 4'd0;
      nib_b = 4'd0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_reg == IDXW'(i)) begin
            nib_a = a_reg[i*4 +: 4];
            nib_b = b_reg[i*4 +: 4];
         end
      end
   end

`ifdef SERIAL_ADD_SUB_EN
   assign b_inv   = {4{sub_reg}};
   assign bus.ovf = ovf_reg;
`else
   assign b_inv   = 4'd0;
`endif

   // ------------------------------------------------------ CLA equations
   assign nib_g    = nib_a & (nib_b ^ b_inv);
   assign nib_p    = nib_a ^ (nib_b ^ b_inv);
   assign nib_c[0] = carry_reg;
   assign nib_c[1] = nib_g[0] | (nib_p[0] & nib_c[0]);
   assign nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0])
                   | (nib_p[1] & nib_p[0] & nib_c[0]);
   assign nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1])
                   | (nib_p[2] & nib_p[1] & nib_g[0])
                   | (nib_p[2] & nib_p[1] & nib_p[0] & nib_c[0]);
   assign nib_c[4] = nib_g[3] | (nib_p[3] & nib_g[2])
                   | (nib_p[3] & nib_p[2] & nib_g[1])
                   | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                   | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & nib_c[0]);
   assign nib_sum  = nib_p ^ nib_c[3:0];

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         idx_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
         sub_reg   <= 1'b0;
         ovf_reg   <= 1'b0;
`endif
      end else begin
         if (accept) begin
            a_reg   <= bus.a;
            b_reg   <= bus.b;
            idx_reg <= '0;
`ifdef SERIAL_ADD_SUB_EN
            sub_reg   <= bus.sub;
            // Subtract is a + ~b + 1, so nibble 0 always gets carry-in 1.
            carry_reg <= bus.sub ? 1'b1 : bus.cin;
`else
            carry_reg <= bus.cin;
`endif
         end else if (state_reg == RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
               if (idx_reg == IDXW'(i)) begin
                  sum_reg[i*4 +: 4] <= nib_sum;
               end
            end
            carry_reg <= nib_c[4];
            if (last_nib) begin
               cout_reg <= nib_c[4];
`ifdef SERIAL_ADD_SUB_EN
               // Carry into the MSB vs carry out of the MSB.
               ovf_reg  <= nib_c[3] ^ nib_c[4];
`endif
            end else begin
               idx_reg <= idx_reg + 1'b1;
            end
         end
      end
   end
endmodule
